// File: rtl/aes_cone_bit_packer.sv
// Packs accepted cone result bits LSB-first into BLOCK_BITS-wide words behind a one-entry output buffer.
// Latency: a word is valid 1 cycle after its last bit is accepted; blk_valid_o is registered.
// Backpressure: bit_ready_o drops only while flushing or when the completing bit has nowhere to go.
module aes_cone_bit_packer #(
    parameter int BLOCK_BITS = 128,
    parameter int CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            bit_i,
    input  logic                            bit_valid_i,
    output logic                            bit_ready_o,
    input  logic                            flush_i,
    output logic [BLOCK_BITS-1:0]           blk_o,
    output logic                            blk_valid_o,
    input  logic                            blk_ready_i,
    output logic [$clog2(BLOCK_BITS+1)-1:0] fill_o,
    output logic [CNT_W-1:0]                blk_cnt_o
);

    localparam int FILL_W = $clog2(BLOCK_BITS + 1);
    localparam logic [FILL_W-1:0] LAST = FILL_W'(BLOCK_BITS - 1);

    logic [BLOCK_BITS-1:0] f_q;
    logic [BLOCK_BITS-1:0] o_q;
    logic [FILL_W-1:0]     fill_q;
    logic                  full_q;
    logic [CNT_W-1:0]      cnt_q;

    logic at_last;
    logic accept;
    logic handoff;
    logic complete;

    assign at_last     = (fill_q == LAST);
    // The completing bit may still enter when the buffer drains in the same cycle.
    assign bit_ready_o = !flush_i && !(at_last && full_q && !blk_ready_i);
    assign accept      = bit_valid_i && bit_ready_o;
    assign handoff     = full_q && blk_ready_i;
    assign complete    = accept && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q    <= '0;
            o_q    <= '0;
            fill_q <= '0;
            full_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (flush_i) begin
                fill_q <= '0;
            end else if (accept) begin
                for (int i = 0; i < BLOCK_BITS; i++) begin
                    if (fill_q == FILL_W'(i)) begin
                        f_q[i] <= bit_i;
                    end
                end
                fill_q <= at_last ? '0 : fill_q + FILL_W'(1);
            end

            if (complete) begin
                o_q    <= {bit_i, f_q[BLOCK_BITS-2:0]};
                full_q <= 1'b1;
            end else if (handoff) begin
                full_q <= 1'b0;
            end

            if (handoff) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign blk_o       = o_q;
    assign blk_valid_o = full_q;
    assign fill_o      = fill_q;
    assign blk_cnt_o   = cnt_q;

endmodule

// File: tb/tb_aes_cone_bit_packer.sv
// Bench for aes_cone_bit_packer: queue-based reference model checked every cycle plus directed literal checks.
module tb_aes_cone_bit_packer;

    localparam int BB = 128;
    localparam int CW = 8;
    localparam int FW = $clog2(BB + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_i;
    logic          bit_valid_i;
    logic          bit_ready_o;
    logic          flush_i;
    logic [BB-1:0] blk_o;
    logic          blk_valid_o;
    logic          blk_ready_i;
    logic [FW-1:0] fill_o;
    logic [CW-1:0] blk_cnt_o;

    aes_cone_bit_packer #(.BLOCK_BITS(BB), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .flush_i     (flush_i),
        .blk_o       (blk_o),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .fill_o      (fill_o),
        .blk_cnt_o   (blk_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: partial word as a bit queue, pending word plus flag, handoff count.
    bit            part[$];
    logic [BB-1:0] m_word;
    bit            m_full;
    int            m_cnt;

    always @(negedge clk) begin
        bit            exp_rdy;
        logic [BB-1:0] w;
        if (!rst_n) begin
            part.delete();
            m_full = 0;
            m_cnt  = 0;
            m_word = '0;
        end
        exp_rdy = !flush_i && !(part.size() == BB - 1 && m_full && !blk_ready_i);
        chk("m_ready", BB'(bit_ready_o), BB'(exp_rdy));
        chk("m_valid", BB'(blk_valid_o), BB'(m_full));
        chk("m_fill",  BB'(fill_o),      BB'(part.size()));
        chk("m_cnt",   BB'(blk_cnt_o),   BB'(m_cnt));
        if (m_full) chk("m_blk", blk_o, m_word);
        if (rst_n) begin
            if (m_full && blk_ready_i) begin
                m_full = 0;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end
            if (flush_i) begin
                part.delete();
            end else if (bit_valid_i && exp_rdy) begin
                part.push_back(bit_i);
                if (part.size() == BB) begin
                    for (int k = 0; k < BB; k++) w[k] = part[k];
                    m_word = w;
                    m_full = 1;
                    part.delete();
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic rand_word(output logic [BB-1:0] w);
        for (int k = 0; k < BB / 32; k++) w[k*32 +: 32] = $urandom;
    endtask

    initial begin
        logic [BB-1:0]   sw;
        logic [2*BB-1:0] bp;
        logic [BB-1:0]   pw;
        logic [BB-1:0]   held;
        int              vcount;

        rst_n = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; flush_i = 1'b0; blk_ready_i = 1'b0;
        cyc(); cyc(); cyc();
        rst_n = 1'b1;

        // Reset / idle
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("idle_valid", BB'(blk_valid_o), '0);
            chk("idle_fill",  BB'(fill_o),      '0);
            chk("idle_cnt",   BB'(blk_cnt_o),   '0);
            chk("idle_ready", BB'(bit_ready_o), BB'(1));
        end

        // Single word
        sw = 128'h0123456789ABCDEF_FEDCBA9876543210;
        blk_ready_i = 1'b1;
        vcount = 0;
        for (int k = 0; k < BB; k++) begin
            bit_i = sw[k]; bit_valid_i = 1'b1;
            cyc();
            if (blk_valid_o) vcount++;
        end
        bit_valid_i = 1'b0;
        chk("single_valid_lat", BB'(blk_valid_o), BB'(1));
        chk("single_blk", blk_o, 128'h0123456789ABCDEF_FEDCBA9876543210);
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (blk_valid_o) vcount++;
        end
        chk("single_vcount", BB'(vcount), BB'(1));
        chk("single_cnt", BB'(blk_cnt_o), BB'(1));

        // Backpressure
        do_reset();
        blk_ready_i = 1'b0;
        rand_word(pw); bp[BB-1:0] = pw;
        rand_word(pw); bp[2*BB-1:BB] = pw;
        for (int k = 0; k < 2 * BB - 1; k++) begin
            bit_i = bp[k]; bit_valid_i = 1'b1;
            cyc();
        end
        bit_i = bp[2*BB-1];
        #1;
        chk("bp_ready_low", BB'(bit_ready_o), '0);
        chk("bp_fill127",   BB'(fill_o),      BB'(127));
        chk("bp_first_held", blk_o, bp[BB-1:0]);
        chk("bp_cnt0",      BB'(blk_cnt_o),   '0);
        blk_ready_i = 1'b1;
        #1;
        chk("bp_ready_high", BB'(bit_ready_o), BB'(1));
        cyc();
        blk_ready_i = 1'b0; bit_valid_i = 1'b0;
        chk("bp_second_valid", BB'(blk_valid_o), BB'(1));
        chk("bp_second_blk",   blk_o, bp[2*BB-1:BB]);
        chk("bp_cnt1",         BB'(blk_cnt_o), BB'(1));
        chk("bp_fill0",        BB'(fill_o), '0);
        blk_ready_i = 1'b1;
        cyc();
        chk("bp_cnt2", BB'(blk_cnt_o), BB'(2));

        // Flush
        for (int k = 0; k < 50; k++) begin
            bit_i = 1'b0; bit_valid_i = 1'b1;
            cyc();
        end
        flush_i = 1'b1; bit_i = 1'b0;
        #1;
        chk("flush_ready", BB'(bit_ready_o), '0);
        cyc();
        flush_i = 1'b0;
        chk("flush_fill", BB'(fill_o), '0);
        for (int k = 0; k < BB; k++) begin
            bit_i = 1'b1; bit_valid_i = 1'b1;
            cyc();
        end
        bit_valid_i = 1'b0;
        chk("flush_word_valid", BB'(blk_valid_o), BB'(1));
        chk("flush_word", blk_o, {BB{1'b1}});
        cyc();

        // Flush with pending output
        blk_ready_i = 1'b0;
        rand_word(pw);
        for (int k = 0; k < BB; k++) begin
            bit_i = pw[k]; bit_valid_i = 1'b1;
            cyc();
        end
        bit_valid_i = 1'b0;
        held = pw;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        cyc();
        chk("fp_valid", BB'(blk_valid_o), BB'(1));
        chk("fp_blk",   blk_o, held);
        blk_ready_i = 1'b1;
        cyc();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit_i       = 1'($urandom);
            bit_valid_i = ($urandom_range(0, 3) != 0);
            blk_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 199) == 0);
            cyc();
        end
        bit_valid_i = 1'b0; flush_i = 1'b0; blk_ready_i = 1'b1;
        cyc(); cyc();

        // Counter wrap
        do_reset();
        blk_ready_i = 1'b1;
        for (int k = 0; k < 256 * BB; k++) begin
            bit_i = 1'($urandom); bit_valid_i = 1'b1;
            cyc();
        end
        bit_valid_i = 1'b0;
        cyc(); cyc();
        chk("wrap_cnt0", BB'(blk_cnt_o), '0);

        // Async reset mid-word with a pending word
        for (int k = 0; k < BB; k++) begin
            bit_i = 1'($urandom); bit_valid_i = 1'b1;
            cyc();
        end
        bit_valid_i = 1'b0;
        cyc();
        blk_ready_i = 1'b0;
        for (int k = 0; k < BB + 77; k++) begin
            bit_i = 1'($urandom); bit_valid_i = 1'b1;
            cyc();
        end
        bit_valid_i = 1'b0;
        chk("pre_rst_fill",  BB'(fill_o),      BB'(77));
        chk("pre_rst_valid", BB'(blk_valid_o), BB'(1));
        chk("pre_rst_cnt",   BB'(blk_cnt_o),   BB'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", BB'(blk_valid_o), '0);
        chk("arst_fill",  BB'(fill_o),      '0);
        chk("arst_cnt",   BB'(blk_cnt_o),   '0);
        chk("arst_blk",   blk_o,            '0);
        chk("arst_ready", BB'(bit_ready_o), BB'(1));
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
